rf_stage: RTL and testbench

Register-read stage of the 6-stage pipeline, directly downstream of the ID/RF pipeline register. It consumes the decoded instruction bundle and reads two operands from the 8×16 architectural register file, which has a write-back port with same-cycle bypass. It sign-extends the selected immediate, detects load-use hazards and generates the stall, and registers everything into the RF/EX pipeline register with bubble and flush insertion.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/rf_stage_if.sv | 54 +++++
 rtl/reg_file_8x16.sv | 45 ++++
 rtl/rf_stage.sv | 82 ++++++++
 tb/tb_rf_stage.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and the RF/EX pipeline register bundle.
package pipe_pkg;

    localparam logic [3:0] NOP_OPCODE = 4'b1111;
    localparam int unsigned MEM_RD_BIT = 0;
    localparam int unsigned MEM_WR_BIT = 1;
    localparam logic [2:0] PC_REG = 3'd7;

    localparam int unsigned WB_W  = 3;
    localparam int unsigned MEM_W = 2;
    localparam int unsigned EX_W  = 4;

    typedef struct packed {
        logic [15:0]      pc;
        logic [15:0]      pc_plus1;
        logic [WB_W-1:0]  wb;
        logic [MEM_W-1:0] memory;
        logic [EX_W-1:0]  ex;
        logic [3:0]       opcode;
        logic [2:0]       dest;
        logic [3:0]       src1;
        logic [3:0]       src2;
        logic [15:0]      rd1;
        logic [15:0]      rd2;
        logic [15:0]      imm16;
        logic             valid;
    } rfex_t;

    // Bubble: everything zero except the NOP opcode.
    function automatic rfex_t rfex_bubble();
        rfex_t b;
        b        = '0;
        b.opcode = NOP_OPCODE;
        return b;
    endfunction

endpackage

// File: rtl/rf_stage_if.sv
// ID/RF -> RF stage -> RF/EX signal bundle, plus write-back and flush inputs.
interface rf_stage_if;
    import pipe_pkg::*;

    logic [15:0]      PC_in;
    logic [15:0]      PC_plus1_in;
    logic [WB_W-1:0]  WB_in;
    logic [MEM_W-1:0] Memory_in;
    logic [EX_W-1:0]  Ex_in;
    logic [3:0]       opcode_in;
    logic [3:0]       src1_in;
    logic [3:0]       src2_in;
    logic [2:0]       dest_in;
    logic [8:0]       imm9_in;
    logic [5:0]       imm6_in;
    logic             Valid_in;
    logic             imm_controller_in;
    logic             wb_we;
    logic [2:0]       wb_addr;
    logic [15:0]      wb_data;
    logic             flush;

    logic             stall_out;
    logic [15:0]      PC_out;
    logic [15:0]      PC_plus1_out;
    logic [WB_W-1:0]  WB_out;
    logic [MEM_W-1:0] Memory_out;
    logic [EX_W-1:0]  Ex_out;
    logic [3:0]       opcode_out;
    logic [2:0]       dest_out;
    logic [3:0]       src1_out;
    logic [3:0]       src2_out;
    logic [15:0]      rd1_out;
    logic [15:0]      rd2_out;
    logic [15:0]      imm16_out;
    logic             Valid_out;

    modport master (
        output PC_in, PC_plus1_in, WB_in, Memory_in, Ex_in, opcode_in, src1_in, src2_in,
               dest_in, imm9_in, imm6_in, Valid_in, imm_controller_in, wb_we, wb_addr,
               wb_data, flush,
        input  stall_out, PC_out, PC_plus1_out, WB_out, Memory_out, Ex_out, opcode_out,
               dest_out, src1_out, src2_out, rd1_out, rd2_out, imm16_out, Valid_out
    );

    modport slave (
        input  PC_in, PC_plus1_in, WB_in, Memory_in, Ex_in, opcode_in, src1_in, src2_in,
               dest_in, imm9_in, imm6_in, Valid_in, imm_controller_in, wb_we, wb_addr,
               wb_data, flush,
        output stall_out, PC_out, PC_plus1_out, WB_out, Memory_out, Ex_out, opcode_out,
               dest_out, src1_out, src2_out, rd1_out, rd2_out, imm16_out, Valid_out
    );

endinterface

// File: rtl/reg_file_8x16.sv
// 8x16 architectural register file: r0-r6 stored, r7 reads as the current PC.
module reg_file_8x16
    import pipe_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  ra1,
    input  logic [2:0]  ra2,
    input  logic [15:0] pc,
    input  logic        we,
    input  logic [2:0]  wa,
    input  logic [15:0] wd,
    output logic [15:0] rd1,
    output logic [15:0] rd2
);

    logic [15:0] mem [PC_REG];
    logic        wr_en;

    assign wr_en = we && (wa != PC_REG);

    // Async read with same-cycle write bypass; r7 never touches the array.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 == PC_REG)               rd1 = pc;
        else if (wr_en && (wa == ra1))   rd1 = wd;
        else                             rd1 = mem[ra1];
        if (ra2 == PC_REG)               rd2 = pc;
        else if (wr_en && (wa == ra2))   rd2 = wd;
        else                             rd2 = mem[ra2];
    end

    // Synchronous clear, then write-back; r7 writes are dropped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(PC_REG); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wa] <= wd;
        end
    end

endmodule

// File: rtl/rf_stage.sv
// Register-read stage: operand fetch, immediate extension, load-use stall, RF/EX register.
module rf_stage
    import pipe_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    rf_stage_if.slave bus
);

    logic [15:0] rd1, rd2, imm16;
    logic        match1, match2, hz;
    rfex_t       rfex_q, rfex_d;

    reg_file_8x16 u_reg_file (
        .clock (clock),
        .reset (reset),
        .ra1   (bus.src1_in[2:0]),
        .ra2   (bus.src2_in[2:0]),
        .pc    (bus.PC_in),
        .we    (bus.wb_we),
        .wa    (bus.wb_addr),
        .wd    (bus.wb_data),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // Sign-extend the selected immediate field.
    always_comb begin
        imm16 = '0;
        if (bus.imm_controller_in) imm16 = {{7{bus.imm9_in[8]}}, bus.imm9_in};
        else                       imm16 = {{10{bus.imm6_in[5]}}, bus.imm6_in};
    end

    // Load-use hazard against the instruction currently held in RF/EX only.
    always_comb begin
        match1 = bus.src1_in[3] && (bus.src1_in[2:0] == rfex_q.dest);
        match2 = bus.src2_in[3] && (bus.src2_in[2:0] == rfex_q.dest);
        hz     = rfex_q.valid && rfex_q.memory[MEM_RD_BIT] && bus.Valid_in && (match1 || match2);
    end

    assign bus.stall_out = hz && !bus.flush;

    // Capture bundle; invalid instructions pass through with controls intact.
    always_comb begin
        rfex_d          = '0;
        rfex_d.pc       = bus.PC_in;
        rfex_d.pc_plus1 = bus.PC_plus1_in;
        rfex_d.wb       = bus.WB_in;
        rfex_d.memory   = bus.Memory_in;
        rfex_d.ex       = bus.Ex_in;
        rfex_d.opcode   = bus.opcode_in;
        rfex_d.dest     = bus.dest_in;
        rfex_d.src1     = bus.src1_in;
        rfex_d.src2     = bus.src2_in;
        rfex_d.rd1      = rd1;
        rfex_d.rd2      = rd2;
        rfex_d.imm16    = imm16;
        rfex_d.valid    = bus.Valid_in;
    end

    // RF/EX register: reset, then flush, then hazard bubble, else capture.
    always_ff @(posedge clock) begin
        if (!reset)               rfex_q <= rfex_bubble();
        else if (bus.flush || hz) rfex_q <= rfex_bubble();
        else                      rfex_q <= rfex_d;
    end

    assign bus.PC_out       = rfex_q.pc;
    assign bus.PC_plus1_out = rfex_q.pc_plus1;
    assign bus.WB_out       = rfex_q.wb;
    assign bus.Memory_out   = rfex_q.memory;
    assign bus.Ex_out       = rfex_q.ex;
    assign bus.opcode_out   = rfex_q.opcode;
    assign bus.dest_out     = rfex_q.dest;
    assign bus.src1_out     = rfex_q.src1;
    assign bus.src2_out     = rfex_q.src2;
    assign bus.rd1_out      = rfex_q.rd1;
    assign bus.rd2_out      = rfex_q.rd2;
    assign bus.imm16_out    = rfex_q.imm16;
    assign bus.Valid_out    = rfex_q.valid;

endmodule

// File: tb/tb_rf_stage.sv
// Self-checking bench for rf_stage: directed scenarios then randomized traffic.
module tb_rf_stage;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    rf_stage_if bus ();

    rf_stage dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Stimulus variables for the next cycle.
    logic        rst_n = 1'b0;
    logic [15:0] in_pc = '0, in_pc1 = '0, in_wdata = '0;
    logic [2:0]  in_wb = '0, in_dest = '0, in_waddr = '0;
    logic [1:0]  in_mem = '0;
    logic [3:0]  in_ex = '0, in_op = '0, in_src1 = '0, in_src2 = '0;
    logic [8:0]  in_imm9 = '0;
    logic [5:0]  in_imm6 = '0;
    logic        in_valid = 1'b0, in_immsel = 1'b0, in_we = 1'b0, in_flush = 1'b0;

    // Reference model: architectural registers and expected RF/EX contents.
    logic [15:0] m_regs [8];
    logic [15:0] e_pc, e_pc1, e_rd1, e_rd2, e_imm;
    logic [2:0]  e_wb, e_dest;
    logic [1:0]  e_mem;
    logic [3:0]  e_ex, e_op, e_src1, e_src2;
    logic        e_valid;
    logic        obs_stall, last_stall;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_bubble();
        {e_pc, e_pc1, e_rd1, e_rd2, e_imm} = '0;
        {e_wb, e_dest, e_mem, e_ex, e_src1, e_src2, e_valid} = '0;
        e_op = 4'b1111;
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] idx);
        if (idx == 3'd7) return in_pc;
        if (in_we && in_waddr != 3'd7 && in_waddr == idx) return in_wdata;
        return m_regs[idx];
    endfunction

    // One clock: drive at negedge, check stall before the edge, check RF/EX after it.
    task automatic step();
        logic        hz, exp_stall;
        logic [15:0] r1, r2, imm;
        @(negedge clock);
        reset                 = rst_n;
        bus.PC_in             = in_pc;
        bus.PC_plus1_in       = in_pc1;
        bus.WB_in             = in_wb;
        bus.Memory_in         = in_mem;
        bus.Ex_in             = in_ex;
        bus.opcode_in         = in_op;
        bus.src1_in           = in_src1;
        bus.src2_in           = in_src2;
        bus.dest_in           = in_dest;
        bus.imm9_in           = in_imm9;
        bus.imm6_in           = in_imm6;
        bus.Valid_in          = in_valid;
        bus.imm_controller_in = in_immsel;
        bus.wb_we             = in_we;
        bus.wb_addr           = in_waddr;
        bus.wb_data           = in_wdata;
        bus.flush             = in_flush;
        #1;
        hz = e_valid && e_mem[0] && in_valid &&
             ((in_src1[3] && in_src1[2:0] == e_dest) || (in_src2[3] && in_src2[2:0] == e_dest));
        exp_stall  = hz && !in_flush;
        obs_stall  = bus.stall_out;
        last_stall = exp_stall;
        check_eq("stall_out", 16'(bus.stall_out), 16'(exp_stall));
        r1  = model_read(in_src1[2:0]);
        r2  = model_read(in_src2[2:0]);
        imm = in_immsel ? 16'($signed(in_imm9)) : 16'($signed(in_imm6));
        @(posedge clock);
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
            set_bubble();
        end else begin
            if (in_we && in_waddr != 3'd7) m_regs[in_waddr] = in_wdata;
            if (in_flush || hz) set_bubble();
            else begin
                e_pc = in_pc; e_pc1 = in_pc1; e_wb = in_wb; e_mem = in_mem; e_ex = in_ex;
                e_op = in_op; e_dest = in_dest; e_src1 = in_src1; e_src2 = in_src2;
                e_rd1 = r1; e_rd2 = r2; e_imm = imm; e_valid = in_valid;
            end
        end
        #1;
        check_eq("PC_out",       bus.PC_out,             e_pc);
        check_eq("PC_plus1_out", bus.PC_plus1_out,       e_pc1);
        check_eq("WB_out",       16'(bus.WB_out),        16'(e_wb));
        check_eq("Memory_out",   16'(bus.Memory_out),    16'(e_mem));
        check_eq("Ex_out",       16'(bus.Ex_out),        16'(e_ex));
        check_eq("opcode_out",   16'(bus.opcode_out),    16'(e_op));
        check_eq("dest_out",     16'(bus.dest_out),      16'(e_dest));
        check_eq("src1_out",     16'(bus.src1_out),      16'(e_src1));
        check_eq("src2_out",     16'(bus.src2_out),      16'(e_src2));
        check_eq("rd1_out",      bus.rd1_out,            e_rd1);
        check_eq("rd2_out",      bus.rd2_out,            e_rd2);
        check_eq("imm16_out",    bus.imm16_out,          e_imm);
        check_eq("Valid_out",    16'(bus.Valid_out),     16'(e_valid));
        check_eq("stall_post",   16'(bus.stall_out),
                 16'(e_valid && e_mem[0] && in_valid &&
                     ((in_src1[3] && in_src1[2:0] == e_dest) ||
                      (in_src2[3] && in_src2[2:0] == e_dest)) && !in_flush));
    endtask

    task automatic plain_instr(input logic [3:0] s1, input logic [3:0] s2, input logic [1:0] mem,
                               input logic [2:0] dest, input logic [3:0] op);
        in_src1 = s1; in_src2 = s2; in_mem = mem; in_dest = dest; in_op = op;
        in_valid = 1'b1; in_we = 1'b0; in_flush = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        set_bubble();
        last_stall = 1'b0;

        // Reset for two cycles.
        rst_n = 1'b0;
        step();
        step();
        check_eq("reset_opcode", 16'(bus.opcode_out), 16'hF);
        check_eq("reset_valid",  16'(bus.Valid_out),  16'h0);
        rst_n = 1'b1;

        // r3 reads zero after reset.
        plain_instr({1'b1, 3'd3}, 4'd0, 2'b00, 3'd1, 4'd0);
        step();
        check_eq("r3_after_reset", bus.rd1_out, 16'h0000);

        // Write r3 then read it back.
        in_valid = 1'b0; in_src1 = '0;
        in_we = 1'b1; in_waddr = 3'd3; in_wdata = 16'h1234;
        step();
        plain_instr({1'b1, 3'd3}, 4'd0, 2'b00, 3'd1, 4'd0);
        step();
        check_eq("r3_readback", bus.rd1_out, 16'h1234);

        // Same-cycle bypass on r5.
        plain_instr(4'd0, {1'b1, 3'd5}, 2'b00, 3'd1, 4'd0);
        in_we = 1'b1; in_waddr = 3'd5; in_wdata = 16'hBEEF;
        step();
        check_eq("r5_bypass", bus.rd2_out, 16'hBEEF);

        // r7 reads PC; immediate extension both ways; r7 write ignored.
        plain_instr({1'b1, 3'd7}, 4'd0, 2'b00, 3'd1, 4'd0);
        in_pc = 16'h0040; in_imm6 = 6'b100000; in_immsel = 1'b0;
        in_we = 1'b1; in_waddr = 3'd7; in_wdata = 16'hDEAD;
        step();
        check_eq("r7_is_pc", bus.rd1_out,   16'h0040);
        check_eq("imm6_ext", bus.imm16_out, 16'hFFE0);
        in_imm9 = 9'h0FF; in_immsel = 1'b1; in_we = 1'b0;
        step();
        check_eq("imm9_ext", bus.imm16_out, 16'h00FF);

        // Load-use on src2: one stall cycle, bubble, then consumer proceeds.
        plain_instr(4'd0, 4'd0, 2'b01, 3'd2, 4'd4);
        step();
        plain_instr(4'd0, {1'b1, 3'd2}, 2'b00, 3'd4, 4'd1);
        step();
        check_eq("lu_stall",     16'(obs_stall),      16'h1);
        check_eq("lu_bubble_v",  16'(bus.Valid_out),  16'h0);
        check_eq("lu_bubble_op", 16'(bus.opcode_out), 16'hF);
        step();
        check_eq("lu_release",   16'(obs_stall),      16'h0);
        check_eq("lu_consumer",  16'(bus.opcode_out), 16'h1);

        // Flush beats hazard.
        plain_instr(4'd0, 4'd0, 2'b01, 3'd2, 4'd4);
        step();
        plain_instr(4'd0, {1'b1, 3'd2}, 2'b00, 3'd4, 4'd1);
        in_flush = 1'b1;
        step();
        check_eq("flush_stall", 16'(obs_stall),     16'h0);
        check_eq("flush_valid", 16'(bus.Valid_out), 16'h0);

        // Unused source matching the load dest does not stall.
        plain_instr(4'd0, 4'd0, 2'b01, 3'd2, 4'd4);
        step();
        plain_instr({1'b0, 3'd2}, {1'b1, 3'd3}, 2'b00, 3'd4, 4'd1);
        step();
        check_eq("unused_src", 16'(obs_stall), 16'h0);

        // Reset asserted during a stall.
        plain_instr(4'd0, 4'd0, 2'b01, 3'd2, 4'd4);
        step();
        plain_instr({1'b1, 3'd2}, 4'd0, 2'b00, 3'd4, 4'd1);
        rst_n = 1'b0;
        step();
        check_eq("rst_mid_stall", 16'(obs_stall),     16'h1);
        check_eq("rst_mid_valid", 16'(bus.Valid_out), 16'h0);
        rst_n = 1'b1;
        step();

        // Randomized traffic; a stalled instruction is held by the upstream stage.
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) begin
                in_pc     = 16'($urandom);
                in_pc1    = in_pc + 16'd1;
                in_wb     = 3'($urandom);
                in_mem    = 2'($urandom);
                in_ex     = 4'($urandom);
                in_op     = 4'($urandom);
                in_src1   = 4'($urandom);
                in_src2   = 4'($urandom);
                in_dest   = 3'($urandom);
                in_imm9   = 9'($urandom);
                in_imm6   = 6'($urandom);
                in_valid  = ($urandom_range(0, 7) != 0);
                in_immsel = 1'($urandom);
            end
            in_we    = 1'($urandom);
            in_waddr = 3'($urandom);
            in_wdata = 16'($urandom);
            in_flush = ($urandom_range(0, 7) == 0);
            rst_n    = ($urandom_range(0, 63) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
